// File: rtl/note_stream_master.sv
// Avalon-MM initiator that advances a table of falling notes once per frame
// and streams one sprite packet per slot plus a score/combo word to the VGA peripheral.
module note_stream_master #(
  parameter int unsigned NUM_SLOTS   = 32,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned Y_LIMIT     = 480,
  parameter logic [15:0] ADDR_SPRITE = 16'h0006,
  parameter logic [15:0] ADDR_SCORE  = 16'h0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [4:0]  load_index,
  input  logic [5:0]  load_n,
  input  logic [9:0]  load_x,
  input  logic [9:0]  load_y,
  input  logic [15:0] score,
  input  logic [15:0] combo,
  output logic [15:0] avm_address,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        missed,
  output logic [7:0]  miss_count,
  output logic        overrun
);

  localparam int unsigned PTR_W = 5;
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_SCORE  = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [NUM_SLOTS-1:0][5:0]  n_q, n_d;
  logic [NUM_SLOTS-1:0][9:0]  x_q, x_d;
  logic [NUM_SLOTS-1:0][9:0]  y_q, y_d;
  logic [15:0]                addr_q, addr_d;
  logic                       cs_q, cs_d;
  logic                       wr_q, wr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic                       busy_q, busy_d;
  logic                       missed_q, missed_d;
  logic [7:0]                 miss_count_q, miss_count_d;
  logic                       overrun_q, overrun_d;

  logic [10:0] sum;
  logic [5:0]  upd_n;
  logic [9:0]  upd_y;

  // Next-state, slot update and bus sequencing
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    n_d          = n_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    cs_d         = cs_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    missed_d     = 1'b0;
    miss_count_d = miss_count_q;
    overrun_d    = overrun_q;
    sum          = 11'd0;
    upd_n        = 6'd0;
    upd_y        = 10'd0;

    case (state_q)
      S_IDLE: begin
        if (load_valid && (32'(load_index) < NUM_SLOTS)) begin
          n_d[load_index] = load_n;
          x_d[load_index] = load_x;
          y_d[load_index] = load_y;
        end
        if (frame_tick) begin
          state_d = S_UPDATE;
          ptr_d   = '0;
        end
      end
      S_UPDATE: begin
        upd_n = n_q[ptr_q];
        upd_y = y_q[ptr_q];
        if (upd_n != 6'd0) begin
          sum = {1'b0, upd_y} + 11'(SPEED);
          if (sum >= 11'(Y_LIMIT)) begin
            upd_n    = 6'd0;
            upd_y    = 10'd0;
            missed_d = 1'b1;
            if (miss_count_q != 8'hFF) miss_count_d = miss_count_q + 8'd1;
          end else begin
            upd_y = sum[9:0];
          end
        end
        n_d[ptr_q] = upd_n;
        y_d[ptr_q] = upd_y;
        // Packet carries the post-update values; empty slots are sent too
        wr_d    = 1'b1;
        cs_d    = 1'b1;
        addr_d  = ADDR_SPRITE;
        wdata_d = {6'(ptr_q), upd_n, upd_y, x_q[ptr_q]};
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!avm_waitrequest) begin
          wr_d = 1'b0;
          cs_d = 1'b0;
          if (ptr_q == LAST_SLOT) begin
            state_d = S_SCORE;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = S_UPDATE;
          end
        end
      end
      default: begin
        // First SCORE cycle launches the write; the second phase waits for acceptance
        if (!wr_q) begin
          wr_d    = 1'b1;
          cs_d    = 1'b1;
          addr_d  = ADDR_SCORE;
          wdata_d = {combo, score};
        end else if (!avm_waitrequest) begin
          wr_d    = 1'b0;
          cs_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase

    if (frame_tick && (state_q != S_IDLE)) overrun_d = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      n_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= 16'd0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= 32'd0;
      busy_q       <= 1'b0;
      missed_q     <= 1'b0;
      miss_count_q <= 8'd0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      n_q          <= n_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      missed_q     <= missed_d;
      miss_count_q <= miss_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign load_ready     = (state_q == S_IDLE) && reset;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign busy           = busy_q;
  assign missed         = missed_q;
  assign miss_count     = miss_count_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_note_stream_master.sv
// Scoreboard bench for note_stream_master: stimulus pushes expected bus writes,
// a monitor pops and compares each accepted Avalon transfer.
module tb_note_stream_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick, load_valid, load_ready;
  logic [4:0]  load_index;
  logic [5:0]  load_n;
  logic [9:0]  load_x, load_y;
  logic [15:0] score, combo;
  logic [15:0] avm_address;
  logic        avm_chipselect, avm_write, avm_waitrequest;
  logic [31:0] avm_writedata;
  logic        busy, missed, overrun;
  logic [7:0]  miss_count;

  note_stream_master dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .load_valid(load_valid), .load_ready(load_ready), .load_index(load_index),
    .load_n(load_n), .load_x(load_x), .load_y(load_y),
    .score(score), .combo(combo),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .missed(missed), .miss_count(miss_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int writes = 0, miss_pulses = 0, busy_run = 0, last_busy = 0;
  logic [47:0] sb[$];
  logic [5:0]  exp_n[32];
  logic [9:0]  exp_x[32];
  logic [9:0]  exp_y[32];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted transfer is matched against the scoreboard head
  always @(negedge clk) begin
    if (reset && avm_write && avm_chipselect && !avm_waitrequest) begin
      writes++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got %h expected none", {avm_address, avm_writedata});
      end else begin
        logic [47:0] e;
        e = sb.pop_front();
        check("bus_write", {avm_address, avm_writedata}, e);
      end
    end
  end

  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
    if (missed) miss_pulses++;
  end

  task automatic push_frame();
    for (int k = 0; k < 32; k++)
      sb.push_back({16'h0006, 6'(k), exp_n[k], exp_y[k], exp_x[k]});
    sb.push_back({16'h0004, combo, score});
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic load(input logic [4:0] idx, input logic [5:0] n, input logic [9:0] x, input logic [9:0] y);
    check("load_ready_idle", 48'(load_ready), 48'h1);
    load_valid = 1'b1; load_index = idx; load_n = n; load_x = x; load_y = y;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("sweep_done", 48'(busy), 48'h0);
    @(negedge clk);
    @(posedge clk); #1;
    check("queue_drained", 48'(sb.size()), 48'h0);
  endtask

  initial begin
    int w0, mp0, n;
    reset = 1'b0; frame_tick = 1'b0; load_valid = 1'b0; load_index = '0;
    load_n = '0; load_x = '0; load_y = '0; avm_waitrequest = 1'b0;
    score = 16'h1234; combo = 16'h0056;
    for (int k = 0; k < 32; k++) begin exp_n[k] = '0; exp_x[k] = '0; exp_y[k] = '0; end

    #2;
    check("rst_outputs", {avm_write, avm_chipselect, busy, missed, overrun, load_ready}, 48'h0);
    check("rst_bus", {avm_address, avm_writedata}, 48'h0);
    check("rst_miss_count", 48'(miss_count), 48'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("load_ready_after_rst", 48'(load_ready), 48'h1);

    // Empty table sweep
    w0 = writes;
    push_frame();
    tick();
    wait_idle();
    check("busy_cycles", 48'(last_busy), 48'd66);
    check("write_count", 48'(writes - w0), 48'd33);

    // Slot 3 moves 2 pixels per frame
    load(5'd3, 6'd5, 10'd100, 10'd200);
    exp_n[3] = 6'd5; exp_x[3] = 10'd100; exp_y[3] = 10'd202;
    push_frame();
    sb[3] = {16'h0006, 32'h0C532864};
    tick();
    wait_idle();
    exp_y[3] = 10'd204;
    push_frame();
    sb[3] = {16'h0006, 32'h0C533064};
    tick();
    wait_idle();

    // Slot 0 falls off the bottom
    load(5'd0, 6'd1, 10'd7, 10'd478);
    exp_n[0] = 6'd0; exp_x[0] = 10'd7; exp_y[0] = 10'd0; exp_y[3] = 10'd206;
    mp0 = miss_pulses;
    push_frame();
    sb[0] = {16'h0006, 32'h00000007};
    tick();
    wait_idle();
    check("missed_pulses", 48'(miss_pulses - mp0), 48'd1);
    check("miss_count_1", 48'(miss_count), 48'd1);
    exp_y[3] = 10'd208;
    push_frame();
    tick();
    wait_idle();
    check("missed_pulses_next", 48'(miss_pulses - mp0), 48'd1);
    check("miss_count_next", 48'(miss_count), 48'd1);

    // Five-cycle stall on slot 7
    exp_y[3] = 10'd210;
    w0 = writes;
    push_frame();
    tick();
    n = 0;
    while (!(avm_write && avm_writedata[31:26] == 6'd7) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("slot7_seen", 48'(avm_write), 48'h1);
    avm_waitrequest = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_addr", 48'(avm_address), 48'h0006);
      check("stall_data", 48'(avm_writedata), 48'h1C000000);
      check("stall_write", 48'({avm_write, avm_chipselect}), 48'h3);
      @(posedge clk); #1;
    end
    avm_waitrequest = 1'b0;
    wait_idle();
    check("stall_busy_cycles", 48'(last_busy), 48'd71);
    check("stall_write_count", 48'(writes - w0), 48'd33);

    // Tick and load attempts during a sweep
    exp_y[3] = 10'd212;
    w0 = writes;
    push_frame();
    tick();
    repeat (3) begin @(posedge clk); #1; end
    frame_tick = 1'b1;
    load_valid = 1'b1; load_index = 5'd3; load_n = 6'd9; load_x = 10'd1; load_y = 10'd1;
    check("load_ready_busy", 48'(load_ready), 48'h0);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    load_valid = 1'b0;
    wait_idle();
    check("overrun", 48'(overrun), 48'h1);
    check("overrun_write_count", 48'(writes - w0), 48'd33);
    check("overrun_busy_cycles", 48'(last_busy), 48'd66);
    exp_y[3] = 10'd214;
    push_frame();
    tick();
    wait_idle();

    // Reset in the middle of a write
    tick();
    n = 0;
    while (!avm_write && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("write_before_rst", 48'(avm_write), 48'h1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_write", {avm_write, avm_chipselect, busy, load_ready}, 48'h0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    check("rst_clears_sticky", {overrun, miss_count}, 48'h0);
    for (int k = 0; k < 32; k++) begin exp_n[k] = '0; exp_x[k] = '0; exp_y[k] = '0; end
    w0 = writes;
    push_frame();
    tick();
    wait_idle();
    check("post_rst_write_count", 48'(writes - w0), 48'd33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
